// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: raster-order pixel source for the ray pipeline.
// Issues (h,v) over valid/ready, bounded by an in-flight credit count.
module pixel_dispatcher #(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int H_BITS         = 10,
  parameter int V_BITS         = 10,
  parameter int FP_BITS        = 32,
  parameter int FP_FRAC        = 16,
  parameter int MAX_INFLIGHT   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [3*FP_BITS-1:0] cam_forward_in,
  input  logic                 ready_in,
  input  logic                 done_in,
  output logic                 valid_out,
  output logic [H_BITS-1:0]    hcount_out,
  output logic [V_BITS-1:0]    vcount_out,
  output logic [FP_BITS-1:0]   hcount_fp_out,
  output logic [FP_BITS-1:0]   vcount_fp_out,
  output logic [3*FP_BITS-1:0] cam_forward_out,
  output logic                 busy_out,
  output logic                 frame_done_out
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [H_BITS-1:0]   h;
  logic [V_BITS-1:0]   v;
  logic [IW-1:0]       inflight;
  logic [3*FP_BITS-1:0] cam;
  logic                fdone;

  logic go;
  logic xfer;
  logic ret;
  logic last_px;
  logic h_end;
  logic finish;

  // The done pulse cycle is already IDLE but must not restart a frame.
  assign go      = (state == IDLE) && start_in && !fdone;
  assign xfer    = valid_out && ready_in;
  assign h_end   = (h == H_BITS'(DISPLAY_WIDTH - 1));
  assign last_px = h_end && (v == V_BITS'(DISPLAY_HEIGHT - 1));
  assign ret     = done_in && (inflight != '0) && (state != IDLE);
  assign finish  = (state == DRAIN) && (inflight == '0);

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = ISSUE;
      ISSUE:   if (xfer && last_px) state_nx = DRAIN;
      DRAIN:   if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded only from registered state and credit count.
  always_comb begin
    valid_out = (state == ISSUE) && (inflight < IW'(MAX_INFLIGHT));
    busy_out  = (state != IDLE);
  end

  // Raster counters; parked at (0,0) once the last pixel leaves.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      h <= '0;
      v <= '0;
    end else if (go) begin
      h <= '0;
      v <= '0;
    end else if (xfer) begin
      if (last_px) begin
        h <= '0;
        v <= '0;
      end else if (h_end) begin
        h <= '0;
        v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Credit counter: issue adds, retire subtracts, both cancel.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      inflight <= '0;
    end else if (go) begin
      inflight <= '0;
    end else if (xfer && !ret) begin
      inflight <= inflight + 1'b1;
    end else if (ret && !xfer) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Per-frame camera vector and the registered completion pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cam   <= '0;
      fdone <= 1'b0;
    end else begin
      if (go) cam <= cam_forward_in;
      fdone <= finish;
    end
  end

  assign hcount_out      = h;
  assign vcount_out      = v;
  assign hcount_fp_out   = FP_BITS'(h) << FP_FRAC;
  assign vcount_fp_out   = FP_BITS'(v) << FP_FRAC;
  assign cam_forward_out = cam;
  assign frame_done_out  = fdone;

endmodule
